// File: rtl/mult_stim_pkg.sv
// ============================================================================
// Module      : mult_stim_pkg
// Description : Shared types and helpers for the multiplier stimulus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_stim_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_vec_table.sv
// ============================================================================
// Module      : mult_vec_table
// Description : Operand-pair register file, one sync write / one comb read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_vec_table #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_a,
    input  logic [WIDTH-1:0]         wr_b,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_a,
    output logic [WIDTH-1:0]         rd_b
);

    // Contents are deliberately not reset so a loaded table survives rst_n.
    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign {rd_a, rd_b} = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/mult_stim_sequencer.sv
// ============================================================================
// Module      : mult_stim_sequencer
// Description : Issues table operand pairs to a start/done multiplier and
//               checks each product against a signed/unsigned reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_stim_sequencer
    import mult_stim_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_a,
    input  logic [WIDTH-1:0]         wr_b,
    input  logic [$clog2(DEPTH):0]   vec_count,
    input  logic                     signed_mode,
    input  logic                     loop_en,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     done_sig,
    input  logic [2*WIDTH-1:0]       product,
    output logic                     start_sig,
    output logic [WIDTH-1:0]         multiplicand,
    output logic [WIDTH-1:0]         multiplier,
    output logic                     busy,
    output logic                     run_done,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH)-1:0] first_fail_idx
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);

    state_t             state;
    state_t             next_state;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      rd_addr;
    logic [AW:0]        run_len;
    logic               run_signed;
    logic               run_loop;
    logic               fail_seen;
    logic [TW-1:0]      timer;
    logic [WIDTH-1:0]   tbl_a;
    logic [WIDTH-1:0]   tbl_b;
    logic [2*WIDTH-1:0] ref_s;
    logic [2*WIDTH-1:0] ref_u;
    logic [2*WIDTH-1:0] ref_prod;
    logic               launch;
    logic               is_last;
    logic               timed_out;
    logic               advance;

    mult_vec_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .rd_addr (rd_addr),
        .rd_a    (tbl_a),
        .rd_b    (tbl_b)
    );

    assign launch    = go && (vec_count != '0);
    assign is_last   = (({1'b0, idx} + (AW+1)'(1)) == run_len);
    assign timed_out = (timer == TMAX);
    assign advance   = !is_last || run_loop;
    assign rd_addr   = (state == GAP && !is_last) ? idx + AW'(1) : '0;

    // Operands are extended to full product width first so the low 2*WIDTH bits are exact.
    assign ref_s    = $signed({{WIDTH{multiplicand[WIDTH-1]}}, multiplicand})
                    * $signed({{WIDTH{multiplier[WIDTH-1]}}, multiplier});
    assign ref_u    = {{WIDTH{1'b0}}, multiplicand} * {{WIDTH{1'b0}}, multiplier};
    assign ref_prod = run_signed ? ref_s : ref_u;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (launch) next_state = WAIT;
                WAIT:    if (done_sig || timed_out) next_state = GAP;
                GAP:     next_state = advance ? WAIT : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_sig      <= 1'b0;
            multiplicand   <= '0;
            multiplier     <= '0;
            run_done       <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_err    <= 1'b0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
            idx            <= '0;
            timer          <= '0;
            run_len        <= '0;
            run_signed     <= 1'b0;
            run_loop       <= 1'b0;
        end else begin
            run_done <= 1'b0;
            if (abort) begin
                start_sig <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        if (vec_count == '0) begin
                            run_done <= 1'b1;
                        end else begin
                            pass_cnt       <= '0;
                            fail_cnt       <= '0;
                            timeout_err    <= 1'b0;
                            first_fail_idx <= '0;
                            fail_seen      <= 1'b0;
                            run_len        <= vec_count;
                            run_signed     <= signed_mode;
                            run_loop       <= loop_en;
                            idx            <= '0;
                            multiplicand   <= tbl_a;
                            multiplier     <= tbl_b;
                            start_sig      <= 1'b1;
                            timer          <= '0;
                        end
                    end
                    WAIT: if (done_sig || timed_out) begin
                        start_sig <= 1'b0;
                        if (done_sig && (product == ref_prod)) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (!fail_seen) begin
                                first_fail_idx <= idx;
                                fail_seen      <= 1'b1;
                            end
                        end
                        if (!done_sig) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                    GAP: if (advance) begin
                        idx          <= rd_addr;
                        multiplicand <= tbl_a;
                        multiplier   <= tbl_b;
                        start_sig    <= 1'b1;
                        timer        <= '0;
                    end else begin
                        run_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_stim_sequencer.sv
// ============================================================================
// Module      : tb_mult_stim_sequencer
// Description : Directed scoreboard bench with a behavioural start/done multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_stim_sequencer;

    localparam int LAT        = 2;
    localparam int R_SIGNED   = 0;
    localparam int R_UNSIGNED = 1;
    localparam int R_FORCE    = 2;
    localparam int R_NEVER    = 3;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_a = '0;
    logic [7:0]  wr_b = '0;
    logic [3:0]  vec_count = '0;
    logic        signed_mode = 1'b0;
    logic        loop_en = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        done_sig = 1'b0;
    logic [15:0] product = '0;
    logic        start_sig;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        run_done;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic        timeout_err;
    logic [2:0]  first_fail_idx;

    pair_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          resp_mode = R_SIGNED;
    logic [15:0] force_val = '0;
    bit          in_flight = 1'b0;
    int          lat = 0;
    int          pulses;
    int          cnt;

    always #5 clk = ~clk;

    mult_stim_sequencer #(.WIDTH(8), .DEPTH(8), .TIMEOUT(255)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_a           (wr_a),
        .wr_b           (wr_b),
        .vec_count      (vec_count),
        .signed_mode    (signed_mode),
        .loop_en        (loop_en),
        .go             (go),
        .abort          (abort),
        .done_sig       (done_sig),
        .product        (product),
        .start_sig      (start_sig),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .busy           (busy),
        .run_done       (run_done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .timeout_err    (timeout_err),
        .first_fail_idx (first_fail_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step; also plays the multiplier under test and pops the scoreboard on each issue.
    task automatic tick();
        pair_t e;
        @(posedge clk);
        #1;
        done_sig = 1'b0;
        if (start_sig !== 1'b1) begin
            in_flight = 1'b0;
        end else if (!in_flight) begin
            in_flight = 1'b1;
            lat = 0;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed issue %0h*%0h expected no issue", multiplicand, multiplier);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("issue_a", multiplicand, e.a);
                check("issue_b", multiplier, e.b);
            end
        end else if (resp_mode != R_NEVER) begin
            lat++;
            if (lat == LAT) begin
                done_sig = 1'b1;
                case (resp_mode)
                    R_SIGNED:   product = $signed(multiplicand) * $signed(multiplier);
                    R_UNSIGNED: product = multiplicand * multiplier;
                    default:    product = force_val;
                endcase
            end
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        pair_t e;
        e.a = a;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic wr_vec(input logic [2:0] addr, input logic [7:0] a, input logic [7:0] b);
        wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] n, input logic sgn, input logic lp);
        vec_count = n; signed_mode = sgn; loop_en = lp; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n_done);
        int n = 0;
        n_done = 0;
        while (busy === 1'b1 && n < bound) begin
            tick();
            n++;
            if (run_done === 1'b1) n_done++;
        end
        check("idle_within_bound", busy, 0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_start"}, start_sig, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_run_done"}, run_done, 0);
        check({pfx, "_mcand"}, multiplicand, 0);
        check({pfx, "_mplier"}, multiplier, 0);
        check({pfx, "_pass"}, pass_cnt, 0);
        check({pfx, "_fail"}, fail_cnt, 0);
        check({pfx, "_tmo"}, timeout_err, 0);
        check({pfx, "_ffi"}, first_fail_idx, 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Signed run with a correct multiplier
        wr_vec(3'd0, 8'd10, 8'd2);
        wr_vec(3'd1, 8'd2, 8'd10);
        wr_vec(3'd2, 8'd11, 8'hFB);
        wr_vec(3'd3, 8'hFB, 8'hF5);
        resp_mode = R_SIGNED;
        push(8'd10, 8'd2); push(8'd2, 8'd10); push(8'd11, 8'hFB); push(8'hFB, 8'hF5);
        start_run(4'd4, 1'b1, 1'b0);
        check("go_to_start", start_sig, 1);
        check("go_busy", busy, 1);
        wait_idle(200, pulses);
        check("sgn_pass", pass_cnt, 4);
        check("sgn_fail", fail_cnt, 0);
        check("sgn_run_done", pulses, 1);
        check("sgn_tmo", timeout_err, 0);

        // Forced product 20: entries 2 and 3 mismatch, first failure at index 2
        resp_mode = R_FORCE; force_val = 16'd20;
        push(8'd10, 8'd2); push(8'd2, 8'd10); push(8'd11, 8'hFB); push(8'hFB, 8'hF5);
        start_run(4'd4, 1'b1, 1'b0);
        wait_idle(200, pulses);
        check("frc_pass", pass_cnt, 2);
        check("frc_fail", fail_cnt, 2);
        check("frc_ffi", first_fail_idx, 2);

        // 251*245: unsigned reference is F037, signed reference is 0037
        wr_vec(3'd0, 8'd251, 8'd245);
        force_val = 16'hF037;
        push(8'd251, 8'd245);
        start_run(4'd1, 1'b0, 1'b0);
        wait_idle(100, pulses);
        check("uns_pass", pass_cnt, 1);
        check("uns_fail", fail_cnt, 0);
        push(8'd251, 8'd245);
        start_run(4'd1, 1'b1, 1'b0);
        wait_idle(100, pulses);
        check("sgnF037_pass", pass_cnt, 0);
        check("sgnF037_fail", fail_cnt, 1);
        check("sgnF037_ffi", first_fail_idx, 0);

        // Timeout on the first vector, second vector still issued and passes
        wr_vec(3'd0, 8'd3, 8'd4);
        wr_vec(3'd1, 8'd5, 8'd6);
        resp_mode = R_NEVER;
        push(8'd3, 8'd4); push(8'd5, 8'd6);
        start_run(4'd2, 1'b0, 1'b0);
        cnt = 0;
        while (start_sig === 1'b1 && cnt < 300) begin
            cnt++;
            tick();
        end
        check("tmo_wait_cycles", cnt, 256);
        check("tmo_err", timeout_err, 1);
        check("tmo_fail", fail_cnt, 1);
        resp_mode = R_UNSIGNED;
        wait_idle(100, pulses);
        check("tmo_next_pass", pass_cnt, 1);
        check("tmo_final_fail", fail_cnt, 1);
        check("tmo_sticky", timeout_err, 1);
        check("tmo_run_done", pulses, 1);

        // Loop of two vectors for three passes, then abort
        for (int i = 0; i < 3; i++) begin
            push(8'd3, 8'd4);
            push(8'd5, 8'd6);
        end
        start_run(4'd2, 1'b0, 1'b1);
        cnt = 0;
        pulses = 0;
        while (pass_cnt !== 16'd6 && cnt < 200) begin
            tick();
            cnt++;
            if (run_done === 1'b1) pulses++;
        end
        check("loop_reached_6", pass_cnt, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_start", start_sig, 0);
        check("abort_busy", busy, 0);
        check("abort_run_done", run_done, 0);
        check("loop_no_run_done", pulses, 0);
        tick();
        check("abort_pass_frozen", pass_cnt, 6);
        check("abort_fail", fail_cnt, 0);
        check("loop_sb_drained", exp_q.size(), 0);

        // go with vec_count=0
        start_run(4'd0, 1'b0, 1'b0);
        check("zero_run_done", run_done, 1);
        check("zero_start", start_sig, 0);
        check("zero_busy", busy, 0);
        tick();
        check("zero_run_done_pulse", run_done, 0);

        // Table write while busy must be dropped
        push(8'd3, 8'd4);
        start_run(4'd1, 1'b0, 1'b0);
        wr_vec(3'd0, 8'd99, 8'd99);
        wait_idle(100, pulses);
        push(8'd3, 8'd4);
        start_run(4'd1, 1'b0, 1'b0);
        wait_idle(100, pulses);
        check("wr_busy_pass", pass_cnt, 1);

        // Reset while in WAIT, then a late done_sig
        resp_mode = R_NEVER;
        push(8'd3, 8'd4);
        start_run(4'd1, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        check_zero("midrst");
        rst_n = 1'b1;
        product = 16'd12;
        done_sig = 1'b1;
        tick();
        check("late_done_busy", busy, 0);
        check("late_done_pass", pass_cnt, 0);
        check("late_done_fail", fail_cnt, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
